// File: rtl/tagged_mem_responder.sv
// ============================================================================
// Module   : tagged_mem_responder
// Purpose  : Memory-side responder for the CPU tagged address/data bus.
//            Holds 64-bit data words plus tags in on-chip RAM, with an
//            auto-incrementing word pointer and a sticky protocol/range error.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tagged_mem_responder #(
    parameter int AW = 12,
    parameter int DW = 64,
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] i_ad,
    input  logic [TW-1:0] i_tag,
    input  logic          i_astb,
    input  logic          i_rd,
    input  logic          i_wr,
    output logic [DW-1:0] o_data,
    output logic [TW-1:0] o_tag,
    output logic          o_valid,
    output logic          o_err,
    output logic [AW-1:0] o_addr
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q,   ptr_d;
    logic            err_q,   err_d;
    logic            valid_q, valid_d;
    logic [DW-1:0]   data_q,  data_d;
    logic [TW-1:0]   tag_q,   tag_d;
    logic            mem_we;

    logic [DW-1:0]   mem    [2**AW];
    logic [TW-1:0]   tagmem [2**AW];

    // Strobe wins over write, write wins over read; losers are silently dropped.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        valid_d = 1'b0;
        data_d  = data_q;
        tag_d   = tag_q;
        mem_we  = 1'b0;
        if (i_astb) begin
            state_d = S_ARMED;
            ptr_d   = i_ad[AW-1:0];
            err_d   = |i_ad[DW-1:AW];
        end else if (i_wr) begin
            if (state_q == S_ARMED) begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + AW'(1);
            end else begin
                err_d  = 1'b1;
            end
        end else if (i_rd) begin
            if (state_q == S_ARMED) begin
                valid_d = 1'b1;
                data_d  = mem[ptr_q];
                tag_d   = tagmem[ptr_q];
                ptr_d   = ptr_q + AW'(1);
            end else begin
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q]    <= i_ad;
            tagmem[ptr_q] <= i_tag;
        end
    end

    assign o_data  = data_q;
    assign o_tag   = tag_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;
    assign o_addr  = ptr_q;

endmodule

`default_nettype wire

// File: tb/tb_tagged_mem_responder.sv
// ============================================================================
// Module   : tb_tagged_mem_responder
// Purpose  : Directed vector table, reset corner sequence and random traffic
//            against an abstract model of tagged_mem_responder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tagged_mem_responder;

    localparam int AW = 12;
    localparam int DW = 64;
    localparam int TW = 8;
    localparam int DEPTH = 2**AW;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] i_ad;
    logic [TW-1:0] i_tag;
    logic          i_astb, i_rd, i_wr;
    logic [DW-1:0] o_data;
    logic [TW-1:0] o_tag;
    logic          o_valid, o_err;
    logic [AW-1:0] o_addr;

    int errors = 0;
    int checks = 0;

    tagged_mem_responder #(.AW(AW), .DW(DW), .TW(TW)) dut (
        .clk     (clk),
        .reset   (rst_n),
        .i_ad    (i_ad),
        .i_tag   (i_tag),
        .i_astb  (i_astb),
        .i_rd    (i_rd),
        .i_wr    (i_wr),
        .o_data  (o_data),
        .o_tag   (o_tag),
        .o_valid (o_valid),
        .o_err   (o_err),
        .o_addr  (o_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Abstract model: sparse memory, integer pointer, flags.
    logic [DW-1:0] m_mem [int];
    logic [TW-1:0] m_tagm[int];
    bit            m_armed;
    int            m_ptr;
    bit            m_err, m_valid, m_known;
    logic [DW-1:0] m_data;
    logic [TW-1:0] m_tag;

    function automatic void model_reset();
        m_armed = 0; m_ptr = 0; m_err = 0; m_valid = 0;
        m_data = '0; m_tag = '0; m_known = 1;
    endfunction

    function automatic void model_step(bit a, bit w, bit r, logic [DW-1:0] ad, logic [TW-1:0] tg);
        m_valid = 0;
        if (a) begin
            m_armed = 1;
            m_ptr   = int'(ad % DEPTH);
            m_err   = (ad / DEPTH) != 0;
        end else if (w) begin
            if (m_armed) begin
                m_mem[m_ptr]  = ad;
                m_tagm[m_ptr] = tg;
                m_ptr = (m_ptr + 1) % DEPTH;
            end else m_err = 1;
        end else if (r) begin
            if (m_armed) begin
                m_valid = 1;
                m_known = m_mem.exists(m_ptr);
                if (m_known) begin
                    m_data = m_mem[m_ptr];
                    m_tag  = m_tagm[m_ptr];
                end
                m_ptr = (m_ptr + 1) % DEPTH;
            end else m_err = 1;
        end
    endfunction

    function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One bus cycle: drive at negedge, model at posedge, outputs settle by #1.
    task automatic cycle(input bit a, input bit w, input bit r,
                         input logic [DW-1:0] ad, input logic [TW-1:0] tg);
        @(negedge clk);
        i_astb = a; i_wr = w; i_rd = r; i_ad = ad; i_tag = tg;
        @(posedge clk);
        model_step(a, w, r, ad, tg);
        #1;
    endtask

    task automatic check_outs(string tag_s, bit v, logic [DW-1:0] d, logic [TW-1:0] t,
                              bit e, logic [AW-1:0] ad);
        chk({tag_s, ".valid"}, DW'(o_valid), DW'(v));
        chk({tag_s, ".data"},  o_data,       d);
        chk({tag_s, ".tag"},   DW'(o_tag),   DW'(t));
        chk({tag_s, ".err"},   DW'(o_err),   DW'(e));
        chk({tag_s, ".addr"},  DW'(o_addr),  DW'(ad));
    endtask

    typedef struct {
        bit            astb, wr, rd;
        logic [DW-1:0] ad;
        logic [TW-1:0] tg;
        bit            e_valid;
        logic [DW-1:0] e_data;
        logic [TW-1:0] e_tag;
        bit            e_err;
        logic [AW-1:0] e_addr;
    } vec_t;

    vec_t tbl[$];

    function automatic void v(bit a, bit w, bit r, logic [DW-1:0] ad, logic [TW-1:0] tg,
                              bit ev, logic [DW-1:0] ed, logic [TW-1:0] et, bit ee,
                              logic [AW-1:0] ea);
        vec_t x;
        x.astb = a; x.wr = w; x.rd = r; x.ad = ad; x.tg = tg;
        x.e_valid = ev; x.e_data = ed; x.e_tag = et; x.e_err = ee; x.e_addr = ea;
        tbl.push_back(x);
    endfunction

    initial begin
        rst_n = 1'b0; i_astb = 0; i_wr = 0; i_rd = 0; i_ad = '0; i_tag = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 0, '0, '0, 0, '0);
        @(negedge clk);
        rst_n = 1'b1;

        //  astb wr rd  ad             tag    | valid data          tag   err addr
        v(0, 0, 1, 64'h0,          8'h00,   0, 64'h0,         8'h00, 1, 12'h000);
        v(1, 0, 0, 64'h005,        8'h00,   0, 64'h0,         8'h00, 0, 12'h005);
        v(1, 0, 0, 64'h010,        8'h00,   0, 64'h0,         8'h00, 0, 12'h010);
        v(0, 1, 0, 64'hA1,         8'h01,   0, 64'h0,         8'h00, 0, 12'h011);
        v(0, 1, 0, 64'hA2,         8'h02,   0, 64'h0,         8'h00, 0, 12'h012);
        v(0, 1, 0, 64'hA3,         8'h03,   0, 64'h0,         8'h00, 0, 12'h013);
        v(1, 0, 0, 64'h010,        8'h00,   0, 64'h0,         8'h00, 0, 12'h010);
        v(0, 0, 1, 64'h0,          8'h00,   1, 64'hA1,        8'h01, 0, 12'h011);
        v(0, 0, 1, 64'h0,          8'h00,   1, 64'hA2,        8'h02, 0, 12'h012);
        v(0, 0, 1, 64'h0,          8'h00,   1, 64'hA3,        8'h03, 0, 12'h013);
        v(0, 0, 0, 64'h0,          8'h00,   0, 64'hA3,        8'h03, 0, 12'h013);
        // pointer wrap
        v(1, 0, 0, 64'hFFF,        8'h00,   0, 64'hA3,        8'h03, 0, 12'hFFF);
        v(0, 1, 0, 64'h11,         8'h11,   0, 64'hA3,        8'h03, 0, 12'h000);
        v(0, 1, 0, 64'h22,         8'h22,   0, 64'hA3,        8'h03, 0, 12'h001);
        v(1, 0, 0, 64'hFFF,        8'h00,   0, 64'hA3,        8'h03, 0, 12'hFFF);
        v(0, 0, 1, 64'h0,          8'h00,   1, 64'h11,        8'h11, 0, 12'h000);
        v(0, 0, 1, 64'h0,          8'h00,   1, 64'h22,        8'h22, 0, 12'h001);
        // range error and its clearing
        v(1, 0, 0, 64'h1000,       8'h00,   0, 64'h22,        8'h22, 1, 12'h000);
        v(1, 0, 0, 64'h001,        8'h00,   0, 64'h22,        8'h22, 0, 12'h001);
        // strobe beats write and read in the same cycle
        v(1, 0, 0, 64'h020,        8'h00,   0, 64'h22,        8'h22, 0, 12'h020);
        v(0, 1, 0, 64'hBEEF,       8'h5A,   0, 64'h22,        8'h22, 0, 12'h021);
        v(1, 1, 0, 64'h020,        8'h77,   0, 64'h22,        8'h22, 0, 12'h020);
        v(1, 0, 1, 64'h020,        8'h00,   0, 64'h22,        8'h22, 0, 12'h020);
        v(0, 0, 1, 64'h0,          8'h00,   1, 64'hBEEF,      8'h5A, 0, 12'h021);
        // write beats read in the same cycle
        v(1, 0, 0, 64'h040,        8'h00,   0, 64'hBEEF,      8'h5A, 0, 12'h040);
        v(0, 1, 1, 64'h99,         8'h09,   0, 64'hBEEF,      8'h5A, 0, 12'h041);
        v(1, 0, 0, 64'h040,        8'h00,   0, 64'hBEEF,      8'h5A, 0, 12'h040);
        v(0, 0, 1, 64'h0,          8'h00,   1, 64'h99,        8'h09, 0, 12'h041);

        foreach (tbl[i]) begin
            cycle(tbl[i].astb, tbl[i].wr, tbl[i].rd, tbl[i].ad, tbl[i].tg);
            check_outs($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_data,
                       tbl[i].e_tag, tbl[i].e_err, tbl[i].e_addr);
        end

        // Reset pulse in the middle of a 4-word read burst.
        cycle(1, 0, 0, 64'h010, 8'h00);
        cycle(0, 0, 1, 64'h0,   8'h00);
        check_outs("burst.w1", 1, 64'hA1, 8'h01, 0, 12'h011);
        cycle(0, 0, 1, 64'h0,   8'h00);
        check_outs("burst.w2", 1, 64'hA2, 8'h02, 0, 12'h012);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outs("midrst", 0, '0, '0, 0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 1, 64'h0, 8'h00);
        check_outs("rst.rd", 0, '0, '0, 1, '0);
        cycle(0, 1, 0, 64'h55, 8'h55);
        check_outs("rst.wr", 0, '0, '0, 1, '0);
        cycle(1, 0, 0, 64'h012, 8'h00);
        check_outs("rst.astb", 0, '0, '0, 0, 12'h012);
        cycle(0, 0, 1, 64'h0, 8'h00);
        check_outs("rst.rd2", 1, 64'hA3, 8'h03, 0, 12'h013);

        // Random traffic checked against the model.
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            int sel;
            bit a, w, r;
            logic [DW-1:0] ad;
            sel = int'($urandom_range(0, 99));
            a = sel < 10;
            w = ($urandom_range(0, 99) < 40);
            r = ($urandom_range(0, 99) < 50);
            if (a) begin
                case ($urandom_range(0, 7))
                    0:       ad = {32'($urandom), 32'($urandom)};
                    1, 2:    ad = DW'(DEPTH - 8 + int'($urandom_range(0, 7)));
                    default: ad = DW'($urandom_range(0, 31));
                endcase
            end else begin
                ad = {32'($urandom), 32'($urandom)};
            end
            cycle(a, w, r, ad, 8'($urandom));
            chk("rnd.valid", DW'(o_valid), DW'(m_valid));
            chk("rnd.err",   DW'(o_err),   DW'(m_err));
            chk("rnd.addr",  DW'(o_addr),  DW'(m_ptr));
            if (m_known) begin
                chk("rnd.data", o_data,      m_data);
                chk("rnd.tag",  DW'(o_tag),  DW'(m_tag));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tagged_mem_responder.md
Name: tagged_mem_responder

Overview:
- Synthesizable memory-side responder for the CPU tagged address/data bus (o_ad/o_tag/o_astb/o_rd/o_wr on the CPU side).
- Latches a word address on an address strobe, then serves single or batch (auto-incrementing) writes and reads of 64-bit data words plus 8-bit tags from on-chip RAM.
- Replaces the behavioural RAM model in CPU benches and FPGA builds.
- Adds address-range checking and a protocol-error flag.

Parameters:
- AW, 12, word address width; RAM depth is 2**AW words.
- DW, 64, data width; must equal the CPU o_ad width.
- TW, 8, tag width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- i_ad  in  DW  address (when i_astb) or write data (when i_wr), from CPU o_ad
- i_tag  in  TW  write tag, from CPU o_tag
- i_astb  in  1  address strobe
- i_rd  in  1  read request, one word per cycle
- i_wr  in  1  write request, one word per cycle
- o_data  out  DW  read data, to CPU i_data
- o_tag  out  TW  read tag, to CPU i_tag
- o_valid  out  1  one-cycle pulse: o_data/o_tag updated this cycle
- o_err  out  1  sticky protocol/range error
- o_addr  out  AW  current word address pointer (debug)

Behaviour:
- Reset (reset=0, asynchronous): o_data=0, o_tag=0, o_valid=0, o_err=0, o_addr=0, state=IDLE. RAM contents are not cleared.
- State machine: IDLE (no address latched) and ARMED. After reset the state is IDLE. Any i_astb moves the state to ARMED. The state never returns to IDLE except by reset.
- Per-edge priority: i_astb > i_wr > i_rd. Lower-priority requests asserted in the same cycle are ignored and flag nothing.
- i_astb:
  - ptr <= i_ad[AW-1:0].
  - o_err <= (i_ad[DW-1:AW] != 0). An out-of-range high part sets o_err; an in-range strobe clears o_err. This is the only way to clear o_err besides reset.
- i_wr in ARMED: mem[ptr] <= i_ad, tagmem[ptr] <= i_tag, ptr <= ptr+1.
- i_rd in ARMED: at the same edge, o_data <= mem[ptr], o_tag <= tagmem[ptr], o_valid <= 1, ptr <= ptr+1.
  - Data is visible one cycle after the cycle i_rd was sampled (one-cycle latency, same as the behavioural model).
- Back-to-back i_rd: one word per cycle. o_valid stays high continuously; no bubbles.
- i_rd or i_wr in IDLE: no RAM access, ptr unchanged, o_valid stays 0, o_err <= 1.
- o_valid is 0 on any edge without an accepted read. o_data/o_tag hold their last value when o_valid is 0.
- ptr wraps modulo 2**AW (0xFFF -> 0x000 at AW=12). Wrap is silent: no error.
- Read-after-write to the same address in the next cycle returns the new data. Write-first RAM bypass is not needed because accesses are sequential, but same-address RAW must be correct.
- o_addr = ptr at all times (registered).
- Reset asserted mid-burst: outputs are cleared immediately; state=IDLE; the next access requires a new i_astb.

Test Plan:
- Reset then i_rd=1 with no strobe -> o_valid stays 0, o_err=1, o_addr=0. Then i_astb with i_ad=0x005 -> o_err=0, o_addr=5.
- i_astb i_ad=0x010; 3 cycles i_wr with data 0xA1/0xA2/0xA3, tags 0x01/0x02/0x03; i_astb 0x010; 3 cycles i_rd -> o_valid high for 3 consecutive cycles, each starting one cycle after its read; o_data/o_tag = A1/01, A2/02, A3/03; final o_addr=0x013.
- i_astb i_ad=0xFFF; write 0x11, 0x22 -> 0x11 stored at 0xFFF, 0x22 at 0x000, o_addr=0x001, o_err=0. Readback from 0xFFF confirms both words.
- i_astb i_ad=0x1000 (AW=12) -> o_err=1, o_addr=0x000. A subsequent i_astb 0x001 -> o_err=0.
- i_astb and i_wr both high in one cycle with i_ad=0x020 -> address latched as 0x020, no write performed. Verify with a readback of the prior contents.
- Mid-burst reset during a 4-word read (pulse reset low after word 2) -> o_valid=0 and o_data=0 immediately. A following i_rd sets o_err=1 until a new strobe.
